// File: rtl/smem_pkg.sv
// Shared SMEM pipeline definitions: slot/line geometry, write-back FSM states and pipeline status codes.
// Used by smem_out_packer (trailer support selected there with SMEM_OUT_TRAILER_EN).
package smem_pkg;

   localparam int LINE_W   = 512;
   localparam int SLOT_W   = 256;
   localparam int X0_LSB   = 0;
   localparam int X1_LSB   = 64;
   localparam int X2_LSB   = 128;
   localparam int INFO_LSB = 192;
   localparam int RNUM_LSB = 248;
   localparam int INFO_W   = RNUM_LSB - INFO_LSB;

   localparam logic [SLOT_W-1:0] PAD_SLOT      = '1;
   localparam logic [31:0]       TRAILER_MAGIC = 32'h534D_454D;

   typedef enum logic [1:0] {
      SMEM_ST_OK,
      SMEM_ST_BUSY,
      SMEM_ST_ERR
   } smem_status_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_TRAILER,
      ST_DRAIN,
      ST_DONE
   } out_state_e;

   // The top byte of info is dropped to make room for the 8-bit read number.
   function automatic logic [SLOT_W-1:0] packSlot(input logic [7:0]  readNum,
                                                  input logic [63:0] x0,
                                                  input logic [63:0] x1,
                                                  input logic [63:0] x2,
                                                  input logic [63:0] info);
      return {readNum, info[INFO_W-1:0], x2, x1, x0};
   endfunction

endpackage

// File: rtl/smem_out_fifo.sv
// First-word-fall-through cache-line FIFO; data_o shows the head entry whenever valid_o is high.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module smem_out_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPush;
   logic             doPop;

   assign doPop   = pop_i & (count_q != '0);
   assign doPush  = push_i & ((count_q != CNT_W'(DEPTH)) | doPop);
   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;
   assign count_o = count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   // Storage carries no reset; entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/smem_out_packer.sv
// SMEM result write-back: packs two 256-bit result slots per 512-bit line, buffers lines, streams them to the host.
// Define SMEM_OUT_TRAILER_EN to append a statistics trailer line after each batch.
module smem_out_packer
   import smem_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int READ_NUM_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [8:0]                batch_size,
   input  logic                      smem_valid,
   input  logic                      smem_last,
   input  logic [READ_NUM_WIDTH-1:0] smem_read_num,
   input  logic [63:0]               smem_x0,
   input  logic [63:0]               smem_x1,
   input  logic [63:0]               smem_x2,
   input  logic [63:0]               smem_info,
   output logic                      stall,
   output logic                      out_valid,
   output logic [LINE_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic                      write_done,
   output logic                      overflow
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   out_state_e                state_q, state_d;
   logic [8:0]                batchSize_q, batchSize_d;
   logic [8:0]                readsDone_q, readsDone_d;
   logic                      halfFull_q, halfFull_d;
   logic [SLOT_W-1:0]         half_q, half_d;
   logic                      overflow_q, overflow_d;
   logic [CNT_W-1:0]          fifoCount;
   logic                      fifoPush;
   logic                      fifoPop;
   logic [LINE_W-1:0]         pushData;
   logic [SLOT_W-1:0]         slotIn;
   logic [READ_NUM_WIDTH+7:0] readNumExt;
   logic                      accept;
   logic                      unusedBits;
`ifdef SMEM_OUT_TRAILER_EN
   logic [15:0]               linesPushed_q, linesPushed_d;
   logic [31:0]               smemAccepted_q, smemAccepted_d;
   logic [LINE_W-1:0]         trailerLine;
`endif

   assign readNumExt = {8'b0, smem_read_num};
   assign unusedBits = ^readNumExt[READ_NUM_WIDTH+7:8];
   assign slotIn     = packSlot(readNumExt[7:0], smem_x0, smem_x1, smem_x2, smem_info);

   assign stall      = (fifoCount >= CNT_W'(FIFO_DEPTH - 1)) || (state_q != ST_RUN);
   assign accept     = smem_valid & ~stall;
   assign fifoPop    = out_valid & out_ready;
   assign write_done = (state_q == ST_DONE);
   assign overflow   = overflow_q;

`ifdef SMEM_OUT_TRAILER_EN
   assign trailerLine = {{(LINE_W-96){1'b0}}, smemAccepted_q, linesPushed_q, 7'b0, readsDone_q, TRAILER_MAGIC};
`endif

   // Line packing and the batch FSM; a read that ends on an even slot is padded so reads never share a line.
   always_comb begin
      state_d     = state_q;
      batchSize_d = batchSize_q;
      readsDone_d = readsDone_q;
      halfFull_d  = halfFull_q;
      half_d      = half_q;
      overflow_d  = overflow_q;
      fifoPush    = 1'b0;
      pushData    = '0;
`ifdef SMEM_OUT_TRAILER_EN
      linesPushed_d  = linesPushed_q;
      smemAccepted_d = smemAccepted_q;
`endif

      if (accept) begin
         if (halfFull_q) begin
            fifoPush   = 1'b1;
            pushData   = {slotIn, half_q};
            halfFull_d = 1'b0;
         end else if (smem_last) begin
            fifoPush = 1'b1;
            pushData = {PAD_SLOT, slotIn};
         end else begin
            half_d     = slotIn;
            halfFull_d = 1'b1;
         end
         if (smem_last) readsDone_d = readsDone_q + 9'd1;
      end

`ifdef SMEM_OUT_TRAILER_EN
      if (accept)   smemAccepted_d = smemAccepted_q + 32'd1;
      if (fifoPush) linesPushed_d  = linesPushed_q + 16'd1;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               batchSize_d = batch_size;
               readsDone_d = '0;
               halfFull_d  = 1'b0;
               overflow_d  = 1'b0;
`ifdef SMEM_OUT_TRAILER_EN
               linesPushed_d  = '0;
               smemAccepted_d = '0;
               state_d = (batch_size == 9'd0) ? ST_TRAILER : ST_RUN;
`else
               state_d = (batch_size == 9'd0) ? ST_DRAIN : ST_RUN;
`endif
            end
         end
         ST_RUN: begin
            if (readsDone_q == batchSize_q) begin
`ifdef SMEM_OUT_TRAILER_EN
               state_d = ST_TRAILER;
`else
               state_d = ST_DRAIN;
`endif
            end
         end
         ST_TRAILER: begin
`ifdef SMEM_OUT_TRAILER_EN
            if ((fifoCount != CNT_W'(FIFO_DEPTH)) || fifoPop) begin
               fifoPush = 1'b1;
               pushData = trailerLine;
               state_d  = ST_DRAIN;
            end
`else
            state_d = ST_DRAIN;
`endif
         end
         ST_DRAIN: begin
            if ((fifoCount == '0) || ((fifoCount == CNT_W'(1)) && fifoPop)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (smem_valid && stall) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         batchSize_q <= '0;
         readsDone_q <= '0;
         halfFull_q  <= 1'b0;
         half_q      <= '0;
         overflow_q  <= 1'b0;
`ifdef SMEM_OUT_TRAILER_EN
         linesPushed_q  <= '0;
         smemAccepted_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         batchSize_q <= batchSize_d;
         readsDone_q <= readsDone_d;
         halfFull_q  <= halfFull_d;
         half_q      <= half_d;
         overflow_q  <= overflow_d;
`ifdef SMEM_OUT_TRAILER_EN
         linesPushed_q  <= linesPushed_d;
         smemAccepted_q <= smemAccepted_d;
`endif
      end
   end

   smem_out_fifo #(
      .WIDTH (LINE_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (fifoPush),
      .data_i  (pushData),
      .pop_i   (fifoPop),
      .valid_o (out_valid),
      .data_o  (out_data),
      .count_o (fifoCount)
   );

endmodule

// File: tb/tb_smem_out_packer.sv
// Directed bench for smem_out_packer (default build, SMEM_OUT_TRAILER_EN undefined).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_smem_out_packer;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic [8:0]   batch_size = '0;
   logic         smem_valid = 1'b0;
   logic         smem_last = 1'b0;
   logic [7:0]   smem_read_num = '0;
   logic [63:0]  smem_x0 = '0;
   logic [63:0]  smem_x1 = '0;
   logic [63:0]  smem_x2 = '0;
   logic [63:0]  smem_info = '0;
   logic         out_ready = 1'b0;
   logic         stall;
   logic         out_valid;
   logic [511:0] out_data;
   logic         write_done;
   logic         overflow;

   int compared = 0;
   int mismatched = 0;

   localparam logic [255:0] PAD = {256{1'b1}};

   always #5 clk = ~clk;

   smem_out_packer #(
      .FIFO_DEPTH     (16),
      .READ_NUM_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .batch_size    (batch_size),
      .smem_valid    (smem_valid),
      .smem_last     (smem_last),
      .smem_read_num (smem_read_num),
      .smem_x0       (smem_x0),
      .smem_x1       (smem_x1),
      .smem_x2       (smem_x2),
      .smem_info     (smem_info),
      .stall         (stall),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .write_done    (write_done),
      .overflow      (overflow)
   );

   // Each result's x1/x2/info are derived from x0; info's top byte is set so truncation is visible.
   function automatic logic [63:0] x1Of(input logic [63:0] x0);
      return x0 ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   function automatic logic [63:0] x2Of(input logic [63:0] x0);
      return ~x0;
   endfunction

   function automatic logic [63:0] infoOf(input logic [63:0] x0);
      return 64'hFF00_0000_0000_0000 | (x0 << 4);
   endfunction

   function automatic logic [255:0] expSlot(input logic [7:0] rn, input logic [63:0] x0);
      logic [63:0] info;
      info = infoOf(x0);
      return {rn, info[55:0], x2Of(x0), x1Of(x0), x0};
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic last, input logic [7:0] rn, input logic [63:0] x0);
      smem_valid    = 1'b1;
      smem_last     = last;
      smem_read_num = rn;
      smem_x0       = x0;
      smem_x1       = x1Of(x0);
      smem_x2       = x2Of(x0);
      smem_info     = infoOf(x0);
      @(posedge clk);
      @(negedge clk);
      smem_valid = 1'b0;
      smem_last  = 1'b0;
   endtask

   task automatic startBatch(input logic [8:0] n);
      start      = 1'b1;
      batch_size = n;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic popLine(input string tag, input logic [511:0] expLine);
      checkOutput({tag, "_valid"}, out_valid, 1'b1);
      checkOutput({tag, "_data"}, out_data, expLine);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      $display("[TB] reset values");
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_stall", stall, 1'b1);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_data", out_data, '0);
      checkOutput("rst_write_done", write_done, 1'b0);
      checkOutput("rst_overflow", overflow, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] single read, two results");
      startBatch(9'd1);
      checkOutput("a_run_stall", stall, 1'b0);
      applyStimulus(1'b0, 8'd0, 64'd1);
      checkOutput("a_half_no_line", out_valid, 1'b0);
      applyStimulus(1'b1, 8'd0, 64'd2);
      checkOutput("a_latency_valid", out_valid, 1'b1);
      checkOutput("a_x0_low", out_data[63:0], 64'd1);
      checkOutput("a_x0_high", out_data[319:256], 64'd2);
      @(negedge clk);
      checkOutput("a_done_before_pop", write_done, 1'b0);
      popLine("a_line", {expSlot(8'd0, 64'd2), expSlot(8'd0, 64'd1)});
      checkOutput("a_empty", out_valid, 1'b0);
      checkOutput("a_write_done", write_done, 1'b1);

      $display("[TB] two reads, padding");
      startBatch(9'd2);
      applyStimulus(1'b0, 8'd0, 64'h10);
      applyStimulus(1'b0, 8'd0, 64'h11);
      applyStimulus(1'b1, 8'd0, 64'h12);
      applyStimulus(1'b1, 8'd1, 64'h20);
      popLine("b_line1", {expSlot(8'd0, 64'h11), expSlot(8'd0, 64'h10)});
      popLine("b_line2", {PAD, expSlot(8'd0, 64'h12)});
      popLine("b_line3", {PAD, expSlot(8'd1, 64'h20)});
      checkOutput("b_empty", out_valid, 1'b0);
      checkOutput("b_write_done", write_done, 1'b1);

      $display("[TB] back-pressure and overflow");
      startBatch(9'd1);
      for (int i = 0; i < 30; i++) begin
         checkOutput($sformatf("c_stall_low_%0d", i), stall, 1'b0);
         applyStimulus(1'b0, 8'd0, 64'(i));
      end
      checkOutput("c_stall_at_15", stall, 1'b1);
      checkOutput("c_no_overflow_yet", overflow, 1'b0);
      applyStimulus(1'b1, 8'd0, 64'd99);
      checkOutput("c_overflow_set", overflow, 1'b1);
      for (int k = 0; k < 15; k++) begin
         popLine($sformatf("c_line%0d", k), {expSlot(8'd0, 64'(2 * k + 1)), expSlot(8'd0, 64'(2 * k))});
      end
      checkOutput("c_no_extra_line", out_valid, 1'b0);
      checkOutput("c_overflow_sticky", overflow, 1'b1);

      $display("[TB] reset mid-batch");
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'd0, 64'(200 + i));
      checkOutput("d_lines_held", out_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("d_rst_out_valid", out_valid, 1'b0);
      checkOutput("d_rst_stall", stall, 1'b1);
      checkOutput("d_rst_overflow", overflow, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("d_no_partial", out_valid, 1'b0);
      startBatch(9'd1);
      applyStimulus(1'b1, 8'd5, 64'd300);
      popLine("d_line", {PAD, expSlot(8'd5, 64'd300)});
      checkOutput("d_empty", out_valid, 1'b0);
      @(negedge clk);
      checkOutput("d_write_done", write_done, 1'b1);

      $display("[TB] empty batch");
      startBatch(9'd0);
      for (int c = 0; c < 2 && write_done !== 1'b1; c++) @(negedge clk);
      checkOutput("e_write_done", write_done, 1'b1);
      checkOutput("e_no_lines", out_valid, 1'b0);
      checkOutput("e_overflow", overflow, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
